// File: rtl/pipearch_common.sv
// Shared pipeline types: BRAM access descriptor and the read_bram job-state encoding.
package pipearch_common;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] offset;
  } bram_access_properties;

  typedef enum logic [1:0] {
    RB_IDLE  = 2'd0,
    RB_ISSUE = 2'd1,
    RB_DRAIN = 2'd2
  } t_readbramstate;

endpackage

// File: rtl/bram_read_fifo.sv
// Synchronous first-word-fall-through FIFO; head_data shows the oldest entry whenever empty is low.
module bram_read_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_next;

  assign count_next = count + CW'(push) - CW'(pop);
  assign head_data  = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; the pointers and empty
  // flag alone decide what is visible, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what makes simultaneous push and pop behave.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/read_bram.sv
// Streams a contiguous range of BRAM lines into a ready/valid consumer, issuing
// reads only while the output FIFO has room for every line already requested.
module read_bram
  import pipearch_common::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_start,
  input  logic [31:0]           configreg,
  output logic                  op_done,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  t_readbramstate        state;
  bram_access_properties props;
  logic [15:0]           issued;
  logic [15:0]           popped;
  logic [READ_LATENCY-1:0] vpipe;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [CW:0]           occ_next;
  logic                  credit;

  assign push      = vpipe[READ_LATENCY-1];
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Lines owed to the FIFO after this edge: still in the BRAM pipe plus stored.
  assign occ_next = {1'b0, inflight} + {1'b0, fifo_count}
                  + (CW+1)'(bram_re) - (CW+1)'(pop);
  assign credit   = occ_next < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe    <= '0;
      inflight <= '0;
    end else begin
      vpipe[0] <= bram_re;
      for (int i = 1; i < READ_LATENCY; i++) vpipe[i] <= vpipe[i-1];
      inflight <= inflight + CW'(bram_re) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RB_IDLE;
      props      <= '0;
      issued     <= '0;
      popped     <= '0;
      bram_re    <= 1'b0;
      bram_raddr <= '0;
      op_done    <= 1'b0;
    end else begin
      op_done <= 1'b0;
      bram_re <= 1'b0;
      if (pop) popped <= popped + 16'd1;
      case (state)
        RB_IDLE: begin
          if (op_start) begin
            props.offset <= 16'(configreg[ADDR_WIDTH-1:0]);
            props.length <= configreg[31:16];
            popped       <= '0;
            if (configreg[31:16] == 16'd0) begin
              issued  <= '0;
              op_done <= 1'b1;
            end else begin
              // The first read goes out immediately; the FIFO is empty here.
              issued     <= 16'd1;
              bram_re    <= 1'b1;
              bram_raddr <= configreg[ADDR_WIDTH-1:0];
              state      <= (configreg[31:16] == 16'd1) ? RB_DRAIN : RB_ISSUE;
            end
          end
        end
        RB_ISSUE: begin
          if (credit) begin
            bram_re    <= 1'b1;
            bram_raddr <= ADDR_WIDTH'(props.offset + issued);
            issued     <= issued + 16'd1;
            if (issued + 16'd1 == props.length) state <= RB_DRAIN;
          end
        end
        RB_DRAIN: begin
          if (pop && (popped + 16'd1 == props.length)) begin
            state   <= RB_IDLE;
            op_done <= 1'b1;
          end
        end
        default: state <= RB_IDLE;
      endcase
    end
  end

  bram_read_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(bram_rdata),
    .pop      (pop),
    .head_data(out_data),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_read_bram.sv
// Directed bench for read_bram: a BRAM model returns line i = i after the read latency.
module tb_read_bram;

  localparam int DW = 512;
  localparam int AW = 16;
  localparam int RL = 2;
  localparam int FD = 8;

  logic          clk;
  logic          reset;
  logic          op_start;
  logic [31:0]   configreg;
  logic          op_done;
  logic          bram_re;
  logic [AW-1:0] bram_raddr;
  logic [DW-1:0] bram_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  int n_total = 0;
  int n_pass  = 0;

  read_bram #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(RL),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_start  (op_start),
    .configreg (configreg),
    .op_done   (op_done),
    .bram_re   (bram_re),
    .bram_raddr(bram_raddr),
    .bram_rdata(bram_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: line at address a holds value a; all-ones when no read was made.
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    rd_pipe[0] <= bram_re ? DW'(bram_raddr) : {DW{1'b1}};
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RL-1];

  // Cumulative observation of the DUT, sampled mid-cycle.
  int            re_total   = 0;
  int            done_total = 0;
  int            max_occ    = 0;
  logic [DW-1:0] popq  [$];
  logic [AW-1:0] addrq [$];
  always @(negedge clk) begin
    if (bram_re) begin
      re_total++;
      addrq.push_back(bram_raddr);
    end
    if (op_done) done_total++;
    if (out_valid && out_ready) popq.push_back(out_data);
    if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] offset, input logic [15:0] len);
    configreg = {len, offset};
    op_start  = 1'b1;
    tick();
    op_start  = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    for (int i = 0; i < budget && done_total == d0; i++) tick();
    ok = (done_total != d0);
  endtask

  task automatic test_reset();
    reset = 1'b1; op_start = 1'b0; configreg = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_total++; if (bram_re !== 1'b0) $display("FAIL reset_re got=%b exp=0", bram_re); else n_pass++;
    n_total++; if (bram_raddr !== '0) $display("FAIL reset_addr got=%h exp=0", bram_raddr); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (op_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", op_done); else n_pass++;
  endtask

  task automatic test_basic();
    logic          e_re, e_valid, e_done;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    out_ready = 1'b1;
    start_job(16'h0010, 16'd4);
    for (int k = 1; k <= 9; k++) begin
      e_re    = (k <= 4);
      e_addr  = AW'(16'h10 + k - 1);
      e_valid = (k >= 4 && k <= 7);
      e_data  = DW'(16'h10 + k - 4);
      e_done  = (k == 8);
      n_total++; if (bram_re !== e_re) $display("FAIL basic_re T+%0d got=%b exp=%b", k, bram_re, e_re); else n_pass++;
      if (e_re) begin
        n_total++; if (bram_raddr !== e_addr) $display("FAIL basic_addr T+%0d got=%h exp=%h", k, bram_raddr, e_addr); else n_pass++;
      end
      n_total++; if (out_valid !== e_valid) $display("FAIL basic_valid T+%0d got=%b exp=%b", k, out_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_total++; if (out_data !== e_data) $display("FAIL basic_data T+%0d got=%h exp=%h", k, out_data[31:0], e_data[31:0]); else n_pass++;
      end
      n_total++; if (op_done !== e_done) $display("FAIL basic_done T+%0d got=%b exp=%b", k, op_done, e_done); else n_pass++;
      tick();
    end
  endtask

  task automatic test_zero_length();
    int r0;
    r0 = re_total;
    out_ready = 1'b1;
    configreg = 32'h0000_0020;
    op_start  = 1'b1;
    tick();
    op_start  = 1'b0;
    n_total++; if (op_done !== 1'b1) $display("FAIL zero_done got=%b exp=1", op_done); else n_pass++;
    tick();
    n_total++; if (op_done !== 1'b0) $display("FAIL zero_done_width got=%b exp=0", op_done); else n_pass++;
    repeat (5) tick();
    n_total++; if (re_total - r0 !== 0) $display("FAIL zero_re got=%0d exp=0", re_total - r0); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL zero_valid got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int r0, q0, d0;
    bit ok;
    r0 = re_total; q0 = popq.size(); d0 = done_total;
    out_ready = 1'b0;
    start_job(16'h0100, 16'd20);
    repeat (30) tick();
    n_total++; if (re_total - r0 !== FD) $display("FAIL bp_stall_count got=%0d exp=%0d", re_total - r0, FD); else n_pass++;
    n_total++; if (bram_re !== 1'b0) $display("FAIL bp_stalled got=%b exp=0", bram_re); else n_pass++;
    out_ready = 1'b1;
    wait_done(d0, 200, ok);
    n_total++; if (!ok) $display("FAIL bp_timeout got=no_done exp=done"); else n_pass++;
    repeat (4) tick();
    n_total++; if (popq.size() - q0 !== 20) $display("FAIL bp_lines got=%0d exp=20", popq.size() - q0); else n_pass++;
    for (int i = 0; i < 20 && q0 + i < popq.size(); i++) begin
      n_total++;
      if (popq[q0+i] !== DW'(16'h100 + i)) $display("FAIL bp_data[%0d] got=%h exp=%h", i, popq[q0+i][31:0], 16'h100 + i);
      else n_pass++;
    end
    n_total++; if (done_total - d0 !== 1) $display("FAIL bp_done_count got=%0d exp=1", done_total - d0); else n_pass++;
  endtask

  task automatic test_wrap();
    int a0, q0, d0;
    bit ok;
    logic [AW-1:0] wexp [4];
    wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
    a0 = addrq.size(); q0 = popq.size(); d0 = done_total;
    out_ready = 1'b1;
    start_job(16'hFFFE, 16'd4);
    wait_done(d0, 50, ok);
    n_total++; if (!ok) $display("FAIL wrap_timeout got=no_done exp=done"); else n_pass++;
    n_total++; if (addrq.size() - a0 !== 4) $display("FAIL wrap_reads got=%0d exp=4", addrq.size() - a0); else n_pass++;
    for (int i = 0; i < 4 && a0 + i < addrq.size(); i++) begin
      n_total++; if (addrq[a0+i] !== wexp[i]) $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, addrq[a0+i], wexp[i]); else n_pass++;
    end
    for (int i = 0; i < 4 && q0 + i < popq.size(); i++) begin
      n_total++; if (popq[q0+i] !== DW'(wexp[i])) $display("FAIL wrap_data[%0d] got=%h exp=%h", i, popq[q0+i][31:0], wexp[i]); else n_pass++;
    end
  endtask

  task automatic test_random_ready();
    int r0, q0, d0;
    r0 = re_total; q0 = popq.size(); d0 = done_total;
    out_ready = 1'b0;
    start_job(16'h0200, 16'd100);
    for (int i = 0; i < 2000 && done_total == d0; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    n_total++; if (done_total == d0) $display("FAIL rand_timeout got=no_done exp=done"); else n_pass++;
    repeat (4) tick();
    n_total++; if (popq.size() - q0 !== 100) $display("FAIL rand_lines got=%0d exp=100", popq.size() - q0); else n_pass++;
    for (int i = 0; i < 100 && q0 + i < popq.size(); i++) begin
      n_total++;
      if (popq[q0+i] !== DW'(16'h200 + i)) $display("FAIL rand_data[%0d] got=%h exp=%h", i, popq[q0+i][31:0], 16'h200 + i);
      else n_pass++;
    end
    n_total++; if (re_total - r0 !== 100) $display("FAIL rand_reads got=%0d exp=100", re_total - r0); else n_pass++;
    n_total++; if (max_occ > FD) $display("FAIL rand_occupancy got=%0d exp<=%0d", max_occ, FD); else n_pass++;
    n_total++; if (done_total - d0 !== 1) $display("FAIL rand_done_count got=%0d exp=1", done_total - d0); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    int q0, d0;
    bit ok;
    q0 = popq.size();
    out_ready = 1'b1;
    start_job(16'h0300, 16'd10);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++; if (bram_re !== 1'b0) $display("FAIL rst_mid_re got=%b exp=0", bram_re); else n_pass++;
    repeat (5) tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_stale got=%b exp=0", out_valid); else n_pass++;
    d0 = done_total;
    start_job(16'h0040, 16'd2);
    wait_done(d0, 50, ok);
    n_total++; if (!ok) $display("FAIL rst_mid_timeout got=no_done exp=done"); else n_pass++;
    repeat (4) tick();
    n_total++; if (popq.size() - q0 !== 2) $display("FAIL rst_mid_lines got=%0d exp=2", popq.size() - q0); else n_pass++;
    for (int i = 0; i < 2 && q0 + i < popq.size(); i++) begin
      n_total++; if (popq[q0+i] !== DW'(16'h40 + i)) $display("FAIL rst_mid_data[%0d] got=%h exp=%h", i, popq[q0+i][31:0], 16'h40 + i); else n_pass++;
    end
    n_total++; if (done_total - d0 !== 1) $display("FAIL rst_mid_done_count got=%0d exp=1", done_total - d0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_backpressure();
    test_wrap();
    test_random_ready();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
